// File: rtl/led_mem_arbiter.sv
// led_mem_arbiter: shares the LED subsystem's single-port 1024x32 RAM between
// a host Avalon-MM master (port 0) and the LED pattern scanner (port 1).
// At most one access is granted per cycle. Grants are round-robin, and port 1
// may lock the RAM for up to HOLD_MAX consecutive grants while port 0 waits.
// Read data returns with a fixed 1-cycle latency, tagged to the issuing port.
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   pN_address/byteenable/read/write/writedata   Avalon-MM requests, N=0,1
//   pN_waitrequest              high when the request is not accepted
//   pN_readdata/readdatavalid   read return (valid one cycle after grant)
//   p1_lock                     port 1 holds the RAM across consecutive grants
//   mem_*                       RAM s1 slave interface
module led_mem_arbiter #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [3:0]        p0_byteenable,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [31:0]       p0_writedata,
  output logic              p0_waitrequest,
  output logic [31:0]       p0_readdata,
  output logic              p0_readdatavalid,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [3:0]        p1_byteenable,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [31:0]       p1_writedata,
  output logic              p1_waitrequest,
  output logic [31:0]       p1_readdata,
  output logic              p1_readdatavalid,
  input  logic              p1_lock,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              mem_reset_req,
  input  logic [31:0]       mem_readdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  logic              req0, req1;
  logic              grant0, grant1;
  logic              lock_active;
  logic              issue_read;
  logic              last;
  logic [CNT_W-1:0]  hold_cnt;
  logic              rd_pend;
  logic              rd_port;
  logic [ADDR_W-1:0] addr_q;

  assign req0 = p0_read | p0_write;
  assign req1 = p1_read | p1_write;

  // Grant selection: lock rule first, then round-robin on contention.
  always_comb begin
    grant0      = 1'b0;
    grant1      = 1'b0;
    lock_active = last & p1_lock & req1 & (hold_cnt < HOLD_LIM);
    if (!reset) begin
      if (lock_active) begin
        grant1 = 1'b1;
      end else if (req0 && req1) begin
        grant0 = last;
        grant1 = ~last;
      end else begin
        grant0 = req0;
        grant1 = req1;
      end
    end
  end

  // Read+write together counts as a write, so only a pure read gets a response.
  assign issue_read = (grant0 & p0_read & ~p0_write) | (grant1 & p1_read & ~p1_write);

  assign p0_waitrequest = ~grant0;
  assign p1_waitrequest = ~grant1;

  // RAM request mux; the address holds its last granted value when idle.
  always_comb begin
    mem_address    = addr_q;
    mem_byteenable = p0_byteenable;
    mem_writedata  = p0_writedata;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (grant1) begin
      mem_address    = p1_address;
      mem_byteenable = p1_byteenable;
      mem_writedata  = p1_writedata;
      mem_chipselect = 1'b1;
      mem_write      = p1_write;
    end else if (grant0) begin
      mem_address    = p0_address;
      mem_chipselect = 1'b1;
      mem_write      = p0_write;
    end
  end

  assign mem_clken     = 1'b1;
  assign mem_reset_req = reset;

  // Arbitration state and read-return tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      last     <= 1'b1;
      hold_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_port  <= 1'b0;
      addr_q   <= '0;
    end else begin
      if (grant0 || grant1) begin
        last   <= grant1;
        addr_q <= mem_address;
      end
      // Count only grants that actually held off a waiting port 0.
      if (!p1_lock || grant0) begin
        hold_cnt <= '0;
      end else if (grant1 && req0 && (hold_cnt < HOLD_LIM)) begin
        hold_cnt <= hold_cnt + CNT_W'(1);
      end
      rd_pend <= issue_read;
      if (issue_read) begin
        rd_port <= grant1;
      end
    end
  end

  assign p0_readdata      = mem_readdata;
  assign p1_readdata      = mem_readdata;
  assign p0_readdatavalid = rd_pend & ~rd_port;
  assign p1_readdatavalid = rd_pend & rd_port;

  // Simultaneous read and write on one port is a master bug.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(p0_read && p0_write));
      assert (!(p1_read && p1_write));
    end
  end

endmodule

// File: tb/tb_led_mem_arbiter.sv
// Directed bench for led_mem_arbiter (HOLD_MAX=4) with a behavioural RAM model
// that registers the address and returns unregistered data.
module tb_led_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  p0_address, p1_address;
  logic [3:0]  p0_byteenable, p1_byteenable;
  logic        p0_read, p0_write, p1_read, p1_write;
  logic [31:0] p0_writedata, p1_writedata;
  logic        p0_waitrequest, p1_waitrequest;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic        p1_lock;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, mem_reset_req;
  logic [31:0] mem_writedata, mem_readdata;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  led_mem_arbiter #(.HOLD_MAX(4), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset),
    .p0_address(p0_address), .p0_byteenable(p0_byteenable),
    .p0_read(p0_read), .p0_write(p0_write), .p0_writedata(p0_writedata),
    .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata),
    .p0_readdatavalid(p0_readdatavalid),
    .p1_address(p1_address), .p1_byteenable(p1_byteenable),
    .p1_read(p1_read), .p1_write(p1_write), .p1_writedata(p1_writedata),
    .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata),
    .p1_readdatavalid(p1_readdatavalid),
    .p1_lock(p1_lock),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_reset_req(mem_reset_req), .mem_readdata(mem_readdata)
  );

  // RAM model: preset contents 0xA50000xx, byte-lane writes, registered address.
  logic [31:0] ram [0:1023];
  logic [9:0]  ram_addr_q;
  bit          ram_init_done;

  always @(posedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'hA500_0000 | 32'(i);
      ram_init_done <= 1'b1;
    end else if (mem_chipselect && mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
    if (mem_clken) ram_addr_q <= mem_address;
  end
  assign mem_readdata = ram[ram_addr_q];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Apply one cycle's requests at the falling edge.
  task automatic drive(input logic r0, input logic w0, input logic [9:0] a0,
                       input logic [3:0] be0, input logic [31:0] d0,
                       input logic r1, input logic [9:0] a1, input logic lock);
    @(negedge clk);
    p0_read = r0; p0_write = w0; p0_address = a0; p0_byteenable = be0; p0_writedata = d0;
    p1_read = r1; p1_write = 1'b0; p1_address = a1; p1_byteenable = 4'hF;
    p1_writedata = 32'h0; p1_lock = lock;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic g1;
    reset = 1'b1;
    p0_read = 0; p0_write = 0; p0_address = '0; p0_byteenable = '0; p0_writedata = '0;
    p1_read = 0; p1_write = 0; p1_address = '0; p1_byteenable = '0; p1_writedata = '0;
    p1_lock = 0;

    // Reset state
    drive(0, 0, 10'h0, 4'h0, 32'h0, 0, 10'h0, 0);
    after_edge();
    @(negedge clk); #1;
    check("rst_wait", {p0_waitrequest, p1_waitrequest}, 32'h3);
    check("rst_valid", {p0_readdatavalid, p1_readdatavalid}, 32'h0);
    check("rst_cs_wr", {mem_chipselect, mem_write}, 32'h0);
    check("rst_req", {mem_reset_req, mem_clken}, 32'h3);
    @(posedge clk); #1;
    reset = 1'b0;

    // Port-0 write then read of 0x005
    drive(0, 1, 10'h005, 4'hF, 32'hDEADBEEF, 0, 10'h0, 0);
    check("wr_wait", p0_waitrequest, 32'h0);
    check("wr_cs_wr_addr", {mem_chipselect, mem_write, 20'h0, mem_address}, {2'b11, 30'h005});
    check("mem_reset_req_low", mem_reset_req, 32'h0);
    after_edge();
    check("wr_no_valid", {p0_readdatavalid, p1_readdatavalid}, 32'h0);
    drive(1, 0, 10'h005, 4'hF, 32'h0, 0, 10'h0, 0);
    check("rd_wait", p0_waitrequest, 32'h0);
    check("rd_cs_wr", {mem_chipselect, mem_write}, 32'h2);
    after_edge();
    check("rd_valid", {p0_readdatavalid, p1_readdatavalid}, 32'h2);
    check("rd_data", p0_readdata, 32'hDEADBEEF);

    // Byte-lane merge, read back via port 1
    drive(0, 1, 10'h010, 4'hF, 32'h11223344, 0, 10'h0, 0);
    drive(0, 1, 10'h010, 4'h2, 32'h0000AB00, 0, 10'h0, 0);
    check("be_wait", p0_waitrequest, 32'h0);
    drive(0, 0, 10'h0, 4'h0, 32'h0, 1, 10'h010, 0);
    check("p1_rd_wait", {p0_waitrequest, p1_waitrequest}, 32'h2);
    after_edge();
    check("p1_rd_valid", {p0_readdatavalid, p1_readdatavalid}, 32'h1);
    check("be_merge_data", p1_readdata, 32'h1122AB44);

    // Contended reads, no lock: strict alternation starting with port 0
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 10'h020, 4'hF, 32'h0, 1, 10'h030, 0);
      g1 = (i % 2) != 0;
      check($sformatf("rr_wait_%0d", i), {p0_waitrequest, p1_waitrequest}, {30'h0, g1, ~g1});
      after_edge();
      check($sformatf("rr_valid_%0d", i), {p0_readdatavalid, p1_readdatavalid}, {30'h0, ~g1, g1});
      check($sformatf("rr_data_%0d", i), g1 ? p1_readdata : p0_readdata,
            g1 ? 32'hA500_0030 : 32'hA500_0020);
    end

    // Lock with HOLD_MAX=4: four port-1 grants, then one port-0 grant
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 10'h020, 4'hF, 32'h0, 1, 10'h030, 1);
      g1 = (i % 5) != 4;
      check($sformatf("lock_wait_%0d", i), {p0_waitrequest, p1_waitrequest}, {30'h0, g1, ~g1});
      after_edge();
      check($sformatf("lock_valid_%0d", i), {p0_readdatavalid, p1_readdatavalid}, {30'h0, ~g1, g1});
    end

    // Port 1 idle with lock held: port 0 never stalls, hold count stays clear
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 10'(10'h040 + i), 4'hF, 32'h0, 0, 10'h0, 1);
      check($sformatf("idle_lock_wait_%0d", i), p0_waitrequest, 32'h0);
      after_edge();
      check($sformatf("idle_lock_data_%0d", i), {31'h0, p0_readdatavalid} ^ 32'h1 ^ p0_readdata,
            32'hA500_0040 + 32'(i));
      check($sformatf("idle_lock_hold_%0d", i), 32'(dut.hold_cnt), 32'h0);
    end

    // Reset raised together with a port-1 read, then first contended grant
    drive(0, 0, 10'h0, 4'h0, 32'h0, 1, 10'h030, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_wait", {p0_waitrequest, p1_waitrequest}, 32'h3);
    check("mid_rst_cs", {mem_chipselect, mem_reset_req}, 32'h1);
    after_edge();
    check("mid_rst_no_valid", {p0_readdatavalid, p1_readdatavalid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 10'h020, 4'hF, 32'h0, 1, 10'h030, 0);
    check("post_rst_grant", {p0_waitrequest, p1_waitrequest}, 32'h1);
    after_edge();
    check("post_rst_valid", {p0_readdatavalid, p1_readdatavalid}, 32'h2);
    check("post_rst_data", p0_readdata, 32'hA500_0020);
    drive(0, 0, 10'h0, 4'h0, 32'h0, 0, 10'h0, 0);
    after_edge();
    check("idle_no_valid", {p0_readdatavalid, p1_readdatavalid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
